// File: rtl/fp_round_pipe_pkg.sv
// Shared FPU rounding types: rounding-mode encoding, flag bit positions and
// exponent helpers used by the rounding stage and its neighbours.
package fp_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rmode_e;

    localparam int FLG_NX = 0;
    localparam int FLG_OF = 1;
    localparam int FLG_RM = 2;

    // Bit order matches the FLG_* indices so the struct can also be indexed.
    typedef struct packed {
        logic rm_err;
        logic overflow;
        logic inexact;
    } fp_flags_t;

    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Valid/ready beat interface of the rounding stage: unrounded operand in,
// packed rounded result and exception flags out.
interface fp_round_pipe_if #(
    parameter int EW = 8,
    parameter int MW = 23
);
    import fp_pkg::*;

    logic            valid_i;
    logic            ready_o;
    logic            sign_i;
    logic [EW-1:0]   exp_i;
    logic [MW-1:0]   man_i;
    logic [2:0]      grs_i;
    logic [2:0]      rmode_i;
    logic            valid_o;
    logic            ready_i;
    logic [EW+MW:0]  result_o;
    fp_flags_t       flags_o;

    modport slave (
        input  valid_i, sign_i, exp_i, man_i, grs_i, rmode_i, ready_i,
        output ready_o, valid_o, result_o, flags_o
    );

    modport master (
        output valid_i, sign_i, exp_i, man_i, grs_i, rmode_i, ready_i,
        input  ready_o, valid_o, result_o, flags_o
    );

endinterface

// File: rtl/fp_round_pipe_inc.sv
// Combinational round-increment decision for one IEEE-754 value; shared by
// several FPU stages, so it carries no state.
module fp_round_inc
    import fp_pkg::*;
(
    input  logic       sign_i,
    input  logic [2:0] grs_i,
    input  logic       lsb_i,
    input  logic [2:0] rmode_i,
    output logic       inc_o,
    output logic       inexact_o,
    output logic       rm_err_o
);

    logic g, r, s;

    assign g         = grs_i[2];
    assign r         = grs_i[1];
    assign s         = grs_i[0];
    assign inexact_o = g | r | s;

    // Unknown encodings round toward zero and raise rm_err.
    always_comb begin
        inc_o    = 1'b0;
        rm_err_o = 1'b0;
        case (rmode_e'(rmode_i))
            RNE:     inc_o = g & (r | s | lsb_i);
            RTZ:     inc_o = 1'b0;
            RDN:     inc_o = sign_i & inexact_o;
            RUP:     inc_o = ~sign_i & inexact_o;
            RMM:     inc_o = g;
            default: rm_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding pipeline: S1 decides the increment, S2 adds it,
// handles specials and overflow saturation, and drives the packed result.
module fp_round_pipe
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fp_round_pipe_if.slave     bus
);

    localparam int W = EW + MW;
    localparam logic [EW-1:0] EXP_ONES = EW'(exp_max(EW));
    localparam logic [EW-1:0] EXP_MAXF = EW'(exp_max(EW) - 1);

    logic            adv;
    logic            inc_d, nx_d, rm_d, special_d;

    logic            s1_valid_q, s1_sign_q, s1_inc_q, s1_nx_q, s1_rm_q, s1_special_q;
    logic [EW-1:0]   s1_exp_q;
    logic [MW-1:0]   s1_man_q;
    logic [2:0]      s1_rmode_q;

    logic            s2_valid_q;
    logic [W:0]      result_q, result_d;
    fp_flags_t       flags_q, flags_d;

    logic [W-1:0]    sum;
    logic [EW-1:0]   sum_exp;
    logic            to_inf;

    // The whole pipe moves as one; a stalled output freezes both stages.
    assign adv          = ~s2_valid_q | bus.ready_i;
    assign bus.ready_o  = adv;
    assign bus.valid_o  = s2_valid_q;
    assign bus.result_o = result_q;
    assign bus.flags_o  = flags_q;

    fp_round_inc u_inc (
        .sign_i    (bus.sign_i),
        .grs_i     (bus.grs_i),
        .lsb_i     (bus.man_i[0]),
        .rmode_i   (bus.rmode_i),
        .inc_o     (inc_d),
        .inexact_o (nx_d),
        .rm_err_o  (rm_d)
    );

    assign special_d = (bus.exp_i == EXP_ONES);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_man_q     <= '0;
            s1_inc_q     <= 1'b0;
            s1_nx_q      <= 1'b0;
            s1_rm_q      <= 1'b0;
            s1_rmode_q   <= '0;
            s1_special_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q   <= bus.valid_i;
            s1_sign_q    <= bus.sign_i;
            s1_exp_q     <= bus.exp_i;
            s1_man_q     <= bus.man_i;
            s1_inc_q     <= inc_d;
            s1_nx_q      <= nx_d;
            s1_rm_q      <= rm_d;
            s1_rmode_q   <= bus.rmode_i;
            s1_special_q <= special_d;
        end
    end

    // Fraction carry ripples into the exponent through the single wide add.
    always_comb begin
        sum      = {s1_exp_q, s1_man_q} + W'(s1_inc_q);
        sum_exp  = sum[W-1:MW];
        to_inf   = 1'b0;
        case (rmode_e'(s1_rmode_q))
            RNE, RMM: to_inf = 1'b1;
            RDN:      to_inf = s1_sign_q;
            RUP:      to_inf = ~s1_sign_q;
            default:  to_inf = 1'b0;
        endcase

        result_d         = {s1_sign_q, sum};
        flags_d          = '0;
        flags_d[FLG_RM]  = s1_rm_q;
        flags_d[FLG_NX]  = s1_nx_q;

        if (s1_special_q) begin
            result_d        = {s1_sign_q, s1_exp_q, s1_man_q};
            flags_d[FLG_NX] = 1'b0;
        end else if (sum_exp == EXP_ONES) begin
            flags_d[FLG_OF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
            result_d = to_inf ? {s1_sign_q, EXP_ONES, {MW{1'b0}}}
                              : {s1_sign_q, EXP_MAXF, {MW{1'b1}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: doc/fp_round_pipe.md
Name: fp_round_pipe

Overview:
- Parametrised, pipelined IEEE-754 rounding stage for the FPU datapath.
- Sits after normalisation in the add/mul paths. It takes a normalised sign/exponent/fraction plus guard/round/sticky bits and produces the rounded, packed result with exception flags.
- Supports any binary format through EW/MW, five rounding modes, carry into the exponent, overflow saturation per mode, and valid/ready backpressure.

Parameters:
- EW, 8, exponent width in bits.
- MW, 23, stored fraction width in bits; the hidden bit is not carried.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat this cycle.
- sign_i  in  1  operand sign.
- exp_i  in  EW  biased exponent, already normalised.
- man_i  in  MW  fraction before rounding.
- grs_i  in  3  {guard, round, sticky}.
- rmode_i  in  3  rounding mode.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts.
- result_o  out  1+EW+MW  packed {sign, exp, frac}.
- flags_o  out  3  {rm_err, overflow, inexact}.

Behaviour:
- Reset: asynchronous on rst_ni low. All valid registers, result_o and flags_o clear to 0. An in-flight beat is discarded, not completed.
- Pipeline: two register stages, S1 then S2 (S2 drives the outputs). Latency is 2 cycles from accept to valid_o. Throughput is 1 beat per cycle.
- Handshake:
  - adv = ~valid_o | ready_i; ready_o = adv.
  - A beat is accepted when valid_i & ready_o.
  - When adv=0, S1 and S2 hold their contents and outputs stay stable.
  - S1 valid loads valid_i & adv. A bubble in S1 propagates as valid_o=0.
- S1, increment decision (g, r, s from grs_i; lsb = man_i[0]):
  - 000 RNE: inc = g & (r | s | lsb).
  - 001 RTZ: inc = 0.
  - 010 RDN: inc = sign & (g | r | s).
  - 011 RUP: inc = ~sign & (g | r | s).
  - 100 RMM: inc = g.
  - 101-111: treated as RTZ; rm_err=1.
  - S1 registers sign, exp, man, inc, inexact = g|r|s, rm_err, rmode, and special = (exp_i == all ones).
- S2, arithmetic:
  - sum = {exp, man} + inc, width EW+MW; the fraction carry ripples naturally into the exponent.
  - If special: pass {sign, exp, man} unchanged; inexact=0, overflow=0, rm_err is still reported.
  - If not special and the sum exponent equals all ones: overflow=1, inexact=1. The result is:
    - Inf = {sign, all ones, 0} for RNE, RMM, RDN with sign=1, and RUP with sign=0.
    - Max finite = {sign, all ones minus 1, all ones} for RTZ, illegal modes, RDN with sign=0, and RUP with sign=1.
  - Otherwise: result = {sign, sum}.
- Boundaries:
  - Fraction all ones with inc=1 gives frac 0 and exp+1.
  - Subnormal input exp=0 is rounded as is; a carry promotes it to exp=1.
  - A zero input with grs=0 gives zero, inexact=0.
  - Simultaneous accept and drain in the same cycle is legal and does not lose beats.

Decomposition:
- Package fp_pkg holds:
  - enum rmode_e: RNE=3'b000, RTZ=3'b001, RDN=3'b010, RUP=3'b011, RMM=3'b100.
  - Flag bit index constants FLG_NX=0, FLG_OF=1, FLG_RM=2.
  - Helper functions exp_max(EW) and the struct fp_flags_t.
- One sub-module, fp_round_inc: the combinational increment decision from sign, grs, lsb and rmode. It is reused by other FPU stages.

Test Plan (EW=8, MW=23, ready_i=1 unless stated):
1. RNE tie-to-even: man=0x000000, grs=100 gives frac 0x000000, NX=1. Then man=0x000001, grs=100 gives 0x000002. valid_o asserts exactly 2 cycles after accept.
2. Carry into exponent: exp=0x7F, man=0x7FFFFF, grs=110, RNE gives exp 0x80, frac 0x000000.
3. Overflow by mode: exp=0xFE, man=0x7FFFFF, grs=111, sign=0.
   - RNE gives 0x7F800000 with OF=NX=1.
   - RTZ gives 0x7F7FFFFF.
   - sign=1 with RUP gives 0xFF7FFFFF.
4. Directed modes, grs=001, man=0x000010:
   - RDN with sign=1 gives 0x000011.
   - RUP with sign=1 gives 0x000010.
   - RMM with grs=100 gives 0x000011.
   - rmode=111 gives RTZ result with rm_err=1.
5. Backpressure: stream 4 beats while ready_i is held low for 3 cycles mid-stream. Expect no loss or duplication, in-order outputs, and result_o stable while stalled; ready_o=0 while valid_o=1 and ready_i=0.
6. Reset and special values:
   - Assert rst_ni low with 2 beats in flight; valid_o drops to 0 immediately and no stale beat appears after release.
   - exp=0xFF, man=0x400000 (NaN) passes unchanged with flags 0.
